// File: rtl/hamming74_byte_sched.sv
// rtl/hamming74_byte_sched.sv - byte scheduler sharing one Hamming(7,4) codec between encode and decode requesters
// Optional corrected-error counter enabled by defining HAMMING_ERRCNT_EN.

module hamming_encoder (
    input  logic [3:0] data,
    output logic [6:0] encoded_data
);
    // Bit i holds codeword position i+1: p1 p2 d0 p4 d1 d2 d3.
    assign encoded_data = {data[3], data[2], data[1],
                           data[1] ^ data[2] ^ data[3],
                           data[0],
                           data[0] ^ data[2] ^ data[3],
                           data[0] ^ data[1] ^ data[3]};
endmodule

module hamming_decoder (
    input  logic [6:0] encoded_data,
    output logic [3:0] data,
    output logic       err
);
    logic [2:0] syndrome;
    logic [6:0] corrected;

    assign syndrome[0] = encoded_data[0] ^ encoded_data[2] ^ encoded_data[4] ^ encoded_data[6];
    assign syndrome[1] = encoded_data[1] ^ encoded_data[2] ^ encoded_data[5] ^ encoded_data[6];
    assign syndrome[2] = encoded_data[3] ^ encoded_data[4] ^ encoded_data[5] ^ encoded_data[6];

    // A non-zero syndrome names the 1-based position of the flipped bit.
    assign corrected = (syndrome == 3'd0) ? encoded_data
                                          : (encoded_data ^ (7'd1 << (syndrome - 3'd1)));
    assign data = {corrected[6], corrected[5], corrected[4], corrected[2]};
    assign err  = (syndrome != 3'd0);
endmodule

module hamming74_byte_sched #(
    parameter int ERR_CNT_W     = 8,
    parameter int RR_EN_DEFAULT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enc_valid,
    output logic                 enc_ready,
    input  logic [7:0]           enc_data,
    input  logic                 dec_valid,
    output logic                 dec_ready,
    input  logic [13:0]          dec_code,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [13:0]          out_data,
    output logic                 out_is_dec,
    output logic [1:0]           out_err,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, LO, HI, OUT} state_t;

    localparam bit RR_EN = (RR_EN_DEFAULT != 0);

    state_t      state, next_state;
    logic        mode_dec;
    logic        last_grant_dec;
    logic [13:0] payload;
    logic        grant_dec;
    logic        handshake;
    logic [3:0]  enc_in;
    logic [6:0]  enc_cw;
    logic [6:0]  dec_in;
    logic [3:0]  dec_data;
    logic        dec_err;

    hamming_encoder u_enc (.data(enc_in), .encoded_data(enc_cw));
    hamming_decoder u_dec (.encoded_data(dec_in), .data(dec_data), .err(dec_err));

    // On a tie the round-robin grant goes to whoever did not win last time.
    assign grant_dec = dec_valid & (~enc_valid | (RR_EN & ~last_grant_dec));
    assign handshake = (state == IDLE) & (enc_valid | dec_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (enc_valid | dec_valid) next_state = LO;
            LO:   next_state = HI;
            HI:   next_state = OUT;
            OUT:  if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        enc_ready = (state == IDLE) & enc_valid & ~grant_dec;
        dec_ready = (state == IDLE) & grant_dec;
        busy      = (state != IDLE);
        out_valid = (state == OUT);
        enc_in    = 4'd0;
        dec_in    = 7'd0;
        if (state == LO) begin
            if (mode_dec) dec_in = payload[6:0];
            else          enc_in = payload[3:0];
        end else if (state == HI) begin
            if (mode_dec) dec_in = payload[13:7];
            else          enc_in = payload[7:4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_dec       <= 1'b0;
            last_grant_dec <= 1'b1;
            payload        <= 14'd0;
            out_data       <= 14'd0;
            out_is_dec     <= 1'b0;
            out_err        <= 2'd0;
        end else begin
            if (handshake) begin
                mode_dec       <= grant_dec;
                last_grant_dec <= grant_dec;
                payload        <= grant_dec ? dec_code : {6'd0, enc_data};
            end
            if (state == LO) begin
                out_is_dec <= mode_dec;
                out_err    <= {1'b0, mode_dec & dec_err};
                out_data   <= mode_dec ? {10'd0, dec_data} : {7'd0, enc_cw};
            end else if (state == HI) begin
                out_err[1] <= mode_dec & dec_err;
                out_data   <= mode_dec ? {6'd0, dec_data, out_data[3:0]}
                                       : {enc_cw, out_data[6:0]};
            end
        end
    end

`ifdef HAMMING_ERRCNT_EN
    logic [1:0]           err_inc;
    logic [ERR_CNT_W:0]   err_sum;
    logic [ERR_CNT_W-1:0] err_count_q;

    // The HI cycle is the last one before OUT, so its increment lands on entry to OUT.
    assign err_inc = (state == HI && mode_dec) ? ({1'b0, out_err[0]} + {1'b0, dec_err}) : 2'd0;
    assign err_sum = {1'b0, err_count_q} + (ERR_CNT_W + 1)'(err_inc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 err_count_q <= '0;
        else if (err_clr)           err_count_q <= '0;
        else if (err_sum[ERR_CNT_W]) err_count_q <= '1;
        else                        err_count_q <= err_sum[ERR_CNT_W-1:0];
    end

    assign err_count = err_count_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_count      = '0;
`endif

endmodule
